// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared FSM state type, slice width and slice-count helper
// for the sequential carry-look-ahead adder controller.
`default_nettype none

package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit carry-look-ahead adder with fully
// expanded carries.
`default_nettype none

module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum = w_p ^ w_c;

endmodule

`default_nettype wire

// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: WIDTH-bit adder that reuses one 4-bit CLA slice over
// WIDTH/4 cycles. Define CLA_SEQ_OVF_EN to add the signed-overflow output ovf.
`default_nettype none

module cla_seq_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = calc_nslice(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IDX_W-1:0] r_idx;

  logic [3:0]       w_a4;
  logic [3:0]       w_b4;
  logic [3:0]       w_s4;
  logic             w_c4;
  logic             w_accept;
  logic             w_last;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_state == RUN) && (r_idx == LAST_IDX);

  always_comb begin
    w_a4 = '0;
    w_b4 = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a4 = r_a[k*SLICE_W +: SLICE_W];
        w_b4 = r_b[k*SLICE_W +: SLICE_W];
      end
    end
  end

  cla4_slice u_slice (
    .a    (w_a4),
    .b    (w_b4),
    .cin  (r_carry),
    .sum  (w_s4),
    .cout (w_c4)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      for (int k = 0; k < NSLICE; k++) begin
        if (r_idx == IDX_W'(k)) r_sum[k*SLICE_W +: SLICE_W] <= w_s4;
      end
      r_carry <= w_c4;
      if (w_last) begin
        r_cout <= w_c4;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

`ifdef CLA_SEQ_OVF_EN
  logic r_ovf;

  // Carry into the MSB xor carry out of it, formed from the live slice result.
  always_ff @(posedge clk) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_last) r_ovf <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s4[3] ^ w_c4;
  end

  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb_cla_seq_adder_ctrl: scoreboard bench for cla_seq_adder_ctrl (WIDTH=16),
// directed corner cases followed by randomized operands and back-pressure.
`default_nettype none

module tb_cla_seq_adder_ctrl;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef CLA_SEQ_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // {ovf, cout, sum}
  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  cla_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int unsigned total;
    int sx, sy, ss;
    logic v;
    total = int'(x) + int'(y) + int'(c);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ss = sx + sy + int'(c);
    v  = (ss > 32767) || (ss < -32768);
    return {v, total[W], total[W-1:0]};
  endfunction

  // Monitor: a result is consumed on any edge where out_valid && out_ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result", 32'(sum), 32'hDEAD);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e[W-1:0]));
        chk("cout", 32'(cout), 32'(e[W]));
`ifdef CLA_SEQ_OVF_EN
        chk("ovf", 32'(ovf), 32'(e[W+1]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set, returns one sample after the acceptance edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                      input bit push);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    a = x; b = y; cin = c; in_valid = 1'b1;
    if (push) exp_q.push_back(model(x, y, c));
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bad_ready;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bad_ready;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Latency and in_ready low across the whole operation.
    send(16'h1234, 16'h4321, 1'b0, 1'b1);
    lat = 1; bad_ready = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready) bad_ready++;
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(NSLICE + 1));
    chk("in_ready_during_op", 32'(bad_ready), 32'd0);

    send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    send(16'h0000, 16'h0000, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b1);
    send(16'h0001, 16'hFFFF, 1'b0, 1'b1);

    // Back-pressure in DONE with new operands offered and ignored.
    wait_done(lat);
    tick();
    out_ready = 1'b0;
    send(16'h1357, 16'h2468, 1'b1, 1'b1);
    wait_done(lat);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'h37C0);
      chk("hold_cout", 32'(cout), 32'd0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("after_ack_in_ready", 32'(in_ready), 32'd1);
    chk("after_ack_out_valid", 32'(out_valid), 32'd0);

    // Reset after two slices discards the operation.
    send(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrun_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_busy", 32'(busy), 32'd0);
    chk("midrun_sum", 32'(sum), 32'd0);
    chk("midrun_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrun_in_ready", 32'(in_ready), 32'd1);
    repeat (8) tick();

    // Randomized operands with random consumer back-pressure.
    for (int i = 0; i < 40; i++) begin
      int n = 0;
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      while (!in_ready && n < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      out_ready = 1'b1;
    end

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        tick();
        n++;
      end
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cla_seq_adder_ctrl.md
# cla_seq_adder_ctrl

Sequencing controller that performs a WIDTH-bit addition by time-multiplexing a single 4-bit carry-look-ahead slice over WIDTH/4 consecutive cycles. The carry is registered between slices. Operands enter and results leave through valid/ready handshakes. The block sits between an operand producer and a result consumer wherever a wide add is needed but area for a full-width CLA is not justified.

## Interface
- WIDTH, 16: operand/result width in bits; multiple of 4, minimum 4.
- NSLICE (localparam), WIDTH/4: number of slice cycles per operation.

- clk, input, 1: single clock, all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operands a, b, cin are presented.
- in_ready, output, 1: block can accept operands.
- a, input, WIDTH: addend A.
- b, input, WIDTH: addend B.
- cin, input, 1: carry into bit 0.
- out_valid, output, 1: sum and cout hold a completed result.
- out_ready, input, 1: consumer accepts the result.
- sum, output, WIDTH: registered result.
- cout, output, 1: registered carry out of bit WIDTH-1.
- busy, output, 1: high in RUN or DONE.
- ovf, output, 1: signed overflow. Present only with CLA_SEQ_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b into operand registers, load cin into the carry register, clear the slice index to 0, and go to RUN.
- **RUN**
  - Each cycle, slice k takes a_reg[4k+3:4k], b_reg[4k+3:4k] and the carry register.
  - The slice's 4-bit sum is written to sum[4k+3:4k], and its carry out is written to the carry register.
  - k increments by 1 each cycle.
  - After slice NSLICE-1 is written: cout is loaded from the final slice carry out, and the FSM goes to DONE.
- **DONE**
  - out_valid=1; sum and cout are held stable.
  - On out_ready, return to IDLE.
- **Outputs**
  - in_ready = (state==IDLE) && !rst.
  - out_valid = (state==DONE).
- **Input handling**
  - in_valid outside IDLE is ignored.
  - a, b, cin changing after acceptance have no effect.
- **Result visibility**
  - sum and cout keep the last result through IDLE until the next acceptance.
  - Partial sum bits update during RUN and are not valid until out_valid.
- **Arithmetic:** modulo 2^WIDTH. {cout,sum} = a + b + cin, exact.
- **Reset**
  - Any state goes to IDLE; the slice index clears.
  - sum=0, cout=0, carry register=0, out_valid=0, busy=0, ovf=0.
  - in_ready=0 while rst is high and 1 in the first cycle after rst falls.
- **Reset mid-RUN or mid-DONE:** the operation is discarded and no out_valid is produced.
- **WIDTH=4:** a single RUN cycle.

## Timing
- Acceptance edge E0 moves the FSM to RUN.
- Slices are processed on edges E1..E(NSLICE).
- out_valid is high from the cycle after E(NSLICE).
- Latency from acceptance edge to out_valid: NSLICE+1 cycles. For WIDTH=16: 5.
- Result handshake edge Ed returns the FSM to IDLE; in_ready is high in the following cycle.
- Minimum initiation interval: NSLICE+2 cycles. No same-cycle accept in DONE.
- The slice path is combinational within one cycle: operand mux, then 4-bit CLA, then registers.

## Configuration
- CLA_SEQ_OVF_EN defined:
  - Adds output ovf.
  - ovf = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ sum[WIDTH-1] ^ cout, registered alongside cout at the last slice.
  - ovf is valid with out_valid, held like sum, and cleared by reset.
- CLA_SEQ_OVF_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package cla_seq_pkg holds:
  - State enum type (IDLE, RUN, DONE).
  - SLICE_W=4.
  - Helper function computing NSLICE from WIDTH.
- One sub-module, cla4_slice: a combinational 4-bit adder.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: sum[3:0], cout.
  - Internals: generate g=a&b, propagate p=a^b, with fully expanded look-ahead carries c0..c3.
- Controller top: FSM, slice index counter, operand/carry/sum registers, and the 4-bit operand select mux.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0; out_valid exactly 5 cycles after the acceptance edge, with in_ready=0 throughout.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. Carry must propagate across all 4 slices.
- a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1; then a=0x0000, b=0x0000, cin=0 → sum=0x0000, cout=0, with no stale carry.
- Hold out_ready=0 for 6 cycles in DONE while driving in_valid with new operands → out_valid, sum, cout stable, in_ready=0, and the new operands ignored. The first out_ready=1 edge leads to in_ready=1 in the next cycle.
- Assert rst for 1 cycle after 2 RUN slices of a=0xAAAA, b=0x5555 → next cycle: out_valid=0, busy=0, sum=0x0000, cout=0; one cycle after rst falls, in_ready=1; no spurious result.
- With CLA_SEQ_OVF_EN:
  - 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1.
  - 0x8000+0x8000 → sum=0x0000, cout=1, ovf=1.
  - 0x0001+0xFFFF → sum=0x0000, cout=1, ovf=0.
